noise_channel_sequencer: RTL and testbench
==========================================

Name: noise_channel_sequencer

Overview:
- Control/sequencing block for sound channel 4 (the noise LFSR datapath).
- Owns the 512 Hz frame sequencer, the 6-bit length counter, the volume envelope, and trigger handling from the NR41/NR42/NR44 register writes.
- Issues a one-cycle LFSR restart pulse to the noise datapath.
- Scales the datapath's 1-bit wave into a 4-bit sample for the mixer.

Parameters:
- FRAME_DIV, 32768, system_clock cycles per frame-sequencer step (16.78 MHz / 512). Legal range is 2..65535.

Ports:
- system_clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- NR41  input  8  length register; [5:0] is the length load value.
- NR42  input  8  envelope register: [7:4] initial volume, [3] direction (1 = up), [2:0] period.
- NR44  input  8  control register: [7] trigger, [6] length enable.
- nr41_write  input  1  one-cycle strobe; NR41 is valid in that cycle.
- nr44_write  input  1  one-cycle strobe; NR44 is valid in that cycle.
- wave  input  1  noise datapath output bit.
- channel_on  output  1  channel active flag.
- volume  output  4  current envelope volume.
- lfsr_restart  output  1  one-cycle pulse that reinitialises the noise LFSR.
- sample  output  4  mixer sample: volume when (channel_on && wave), else 0.

Behaviour:
- Reset values: channel_on=0, volume=0, lfsr_restart=0, sample=0, length_counter=0, frame step=0, divider=0, env_timer=0, env_state=ENV_IDLE, len_en=0.
- Frame divider: counts 0..FRAME_DIV-1. frame_tick is asserted for one cycle when it wraps. On each tick, step advances 0..7 and wraps to 0.
- Length clocking: occurs on ticks that leave step at an even value (0, 2, 4, 6).
  - Condition: len_en=1 and length_counter!=0.
  - Action: decrement; on reaching 0, channel_on <= 0 in the same clock edge.
- Envelope clocking: occurs on the tick that leaves step at 7.
- NR41 write: length_counter <= 64 - NR41[5:0]; the 7-bit result ranges 1..64. len_en and channel_on are unchanged.
- NR44 write: len_en <= NR44[6] on every write.
- Trigger (nr44_write && NR44[7]):
  - channel_on <= dac_on, where dac_on = (NR42[7:3] != 0).
  - If length_counter==0, it loads 64.
  - volume <= NR42[7:4].
  - env_timer <= NR42[2:0].
  - env_state <= ENV_RUN if NR42[2:0]!=0, else ENV_IDLE.
  - lfsr_restart is high in the cycle after the strobe, for exactly one cycle.
- Envelope FSM:
  - ENV_IDLE: no change. Entered on reset, or on trigger with period 0.
  - ENV_RUN: on each envelope tick, env_timer decrements.
    - When env_timer hits 0, it reloads NR42[2:0].
    - Direction up and volume<15: volume+1.
    - Direction down and volume>0: volume-1.
    - If the step lands volume on 15 (up) or 0 (down), next state is ENV_DONE.
  - ENV_DONE: volume frozen until the next trigger.
- DAC off: whenever dac_on==0, channel_on <= 0 on the next edge, regardless of other events.
- Simultaneous events:
  - Trigger and length tick in the same cycle: the trigger wins and no decrement is applied.
  - Trigger and envelope tick in the same cycle: trigger reload wins.
  - nr41_write and length tick in the same cycle: the load wins.
- Register inputs (NR41/NR42/NR44) are sampled only on their strobes, except NR42, which is read live at trigger and reload.
- Reset mid-operation: all state returns to the reset values asynchronously. The divider phase restarts at 0.
- Latency:
  - sample is registered, with one cycle of latency from wave/volume/channel_on.
  - channel_on rises 1 cycle after the trigger strobe.

Optional Feature:
- Macro: NOISE_SEQ_EXTRA_LEN_CLOCK_EN.
- With the macro defined:
  - Condition: an NR44 write takes len_en 0->1 while the current step is even (the next tick will not clock length), and length_counter!=0.
  - Action: length_counter decrements immediately on that edge.
  - If this reaches 0 and NR44[7]=0, channel_on <= 0.
  - If NR44[7]=1 in the same write, the trigger's load of 64 (when the count is 0) happens after the extra clock.
- Without the macro: no extra clocking; len_en changes only gate future ticks.

Test Plan (FRAME_DIV=4 on all benches):
- Reset → all outputs 0. Assert reset mid-envelope at volume=9 → volume=0, channel_on=0 immediately.
- NR42=8'hF0, trigger → volume=15, channel_on=1 after 1 cycle, lfsr_restart high 1 cycle. With wave=1 → sample=15; with wave=0 → sample=0.
- NR41=8'h3E (length 2), NR44=8'hC0 → channel_on drops to 0 on the 2nd even-step tick; sample=0 thereafter.
- NR42=8'h51 (vol 5, down, period 1), trigger → volume 4, 3, 2, 1, 0 on successive step-7 ticks, then stays 0 (ENV_DONE). NR42=8'hE9 (vol 14, up) → volume 15 after one step-7 tick, then frozen.
- NR42=8'h07 (DAC off), trigger → channel_on stays 0, lfsr_restart still pulses, sample=0.
- NR41=8'h3F (length 1), then NR44=8'h40 written at an even step: with NOISE_SEQ_EXTRA_LEN_CLOCK_EN → length reaches 0 and channel_on=0 at the write edge; without it → channel_on=0 only at the next even-step tick.

Source files
------------

// File: rtl/noise_channel_sequencer_if.sv
// Register/strobe bus between the APU register file and the channel 4
// sequencer. It carries the write strobes and register values, the
// datapath wave bit, and the channel outputs for the mixer.
interface noise_channel_sequencer_if;
  logic [7:0] NR41;
  logic [7:0] NR42;
  logic [7:0] NR44;
  logic       nr41_write;
  logic       nr44_write;
  logic       wave;
  logic       channel_on;
  logic [3:0] volume;
  logic       lfsr_restart;
  logic [3:0] sample;

  // Register file / datapath side.
  modport master (
    output NR41, NR42, NR44, nr41_write, nr44_write, wave,
    input  channel_on, volume, lfsr_restart, sample
  );

  // Sequencer side.
  modport slave (
    input  NR41, NR42, NR44, nr41_write, nr44_write, wave,
    output channel_on, volume, lfsr_restart, sample
  );
endinterface

// File: rtl/noise_channel_sequencer.sv
// Channel 4 (noise) control block. It contains the 512 Hz frame sequencer,
// the 6-bit length counter, the volume envelope, trigger handling, the LFSR
// restart pulse and the 4-bit mixer sample.
// Optional feature: define NOISE_SEQ_EXTRA_LEN_CLOCK_EN to enable the extra
// length clock. That clock fires when an NR44 write enables length while the
// current step is even.
module noise_channel_sequencer #(
  parameter int unsigned FRAME_DIV = 32768  // system_clock cycles per frame step (2..65535)
) (
  input  logic                        system_clock,
  input  logic                        reset,
  noise_channel_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    ENV_IDLE = 2'd0,
    ENV_RUN  = 2'd1,
    ENV_DONE = 2'd2
  } env_state_t;

  localparam logic [15:0] DIV_LAST = 16'(FRAME_DIV - 1);

  logic [15:0] divider;
  logic [2:0]  step;
  logic [2:0]  step_next;
  logic        frame_tick;
  logic        length_tick;
  logic        envelope_tick;

  logic        trigger;
  logic        dac_on;
  logic        extra_clock;

  logic [6:0]  length_counter;
  logic [6:0]  length_next;
  logic [6:0]  length_dec;
  logic        length_zeroed;
  logic        len_en;

  env_state_t  env_state;
  env_state_t  env_state_next;
  logic [2:0]  env_timer;
  logic [2:0]  env_timer_next;
  logic [3:0]  volume_q;
  logic [3:0]  volume_next;

  logic        channel_on_q;

  // The tick fires in the cycle the divider wraps. Length and envelope
  // events depend on the step value that the tick leaves behind.
  assign frame_tick    = (divider == DIV_LAST);
  assign step_next     = step + 3'd1;
  assign length_tick   = frame_tick && !step_next[0];
  assign envelope_tick = frame_tick && (step_next == 3'd7);

  assign trigger    = bus.nr44_write && bus.NR44[7];
  assign dac_on     = |bus.NR42[7:3];
  assign length_dec = length_counter - 7'd1;

`ifdef NOISE_SEQ_EXTRA_LEN_CLOCK_EN
  // Enabling length during an even step would otherwise skip one clock, so
  // that clock is applied on the write edge itself.
  assign extra_clock = bus.nr44_write && bus.NR44[6] && !len_en && !step[0]
                       && (length_counter != 7'd0);
`else
  assign extra_clock = 1'b0;
`endif

  // Frame divider and the 8-step sequencer position.
  always_ff @(posedge system_clock or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments so that every
    // register samples pre-edge values, whatever order the blocks run in.
    if (reset) begin
      divider <= '0;
      step    <= '0;
    end else if (frame_tick) begin
      divider <= '0;
      step    <= step_next;
    end else begin
      divider <= divider + 16'd1;
    end
  end

  // Length counter next value. The priority is: NR41 load, then the extra
  // clock, then the trigger reload, then the frame length tick.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    length_next   = length_counter;
    length_zeroed = 1'b0;
    if (bus.nr41_write) begin
      length_next = 7'd64 - {1'b0, bus.NR41[5:0]};
    end else if (extra_clock) begin
      length_next = length_dec;
      if (length_dec == 7'd0) begin
        if (trigger) length_next = 7'd64;
        else         length_zeroed = 1'b1;
      end
    end else if (trigger) begin
      if (length_counter == 7'd0) length_next = 7'd64;
    end else if (length_tick && len_en && (length_counter != 7'd0)) begin
      length_next   = length_dec;
      length_zeroed = (length_dec == 7'd0);
    end
  end

  // Length counter and length enable registers.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      length_counter <= '0;
      len_en         <= 1'b0;
    end else begin
      length_counter <= length_next;
      if (bus.nr44_write) len_en <= bus.NR44[6];
    end
  end

  // Channel enable. A DAC that is off always wins; otherwise a trigger
  // turns the channel on, and length expiry turns it off.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset)              channel_on_q <= 1'b0;
    else if (!dac_on)       channel_on_q <= 1'b0;
    else if (trigger)       channel_on_q <= 1'b1;
    else if (length_zeroed) channel_on_q <= 1'b0;
  end

  // Envelope FSM state register, together with the volume and timer.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      env_state <= ENV_IDLE;
      env_timer <= '0;
      volume_q  <= '0;
    end else begin
      env_state <= env_state_next;
      env_timer <= env_timer_next;
      volume_q  <= volume_next;
    end
  end

  // Envelope next state. A trigger reload beats a same-cycle envelope tick.
  // NR42 is read live both on trigger and on each period reload.
  always_comb begin
    env_state_next = env_state;
    env_timer_next = env_timer;
    volume_next    = volume_q;
    if (trigger) begin
      volume_next    = bus.NR42[7:4];
      env_timer_next = bus.NR42[2:0];
      env_state_next = (bus.NR42[2:0] != 3'd0) ? ENV_RUN : ENV_IDLE;
    end else if (envelope_tick) begin
      unique case (env_state)
        ENV_RUN: begin
          if (env_timer > 3'd1) begin
            env_timer_next = env_timer - 3'd1;
          end else begin
            env_timer_next = bus.NR42[2:0];
            if (bus.NR42[3]) begin
              if (volume_q != 4'd15) volume_next = volume_q + 4'd1;
              if (volume_q >= 4'd14) env_state_next = ENV_DONE;
            end else begin
              if (volume_q != 4'd0) volume_next = volume_q - 4'd1;
              if (volume_q <= 4'd1) env_state_next = ENV_DONE;
            end
          end
        end
        default: begin
          // ENV_IDLE and ENV_DONE hold the volume until the next trigger.
        end
      endcase
    end
  end

  // LFSR restart pulse, and the registered mixer sample.
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      bus.lfsr_restart <= 1'b0;
      bus.sample       <= '0;
    end else begin
      bus.lfsr_restart <= trigger;
      bus.sample       <= (channel_on_q && bus.wave) ? volume_q : 4'd0;
    end
  end

  assign bus.channel_on = channel_on_q;
  assign bus.volume     = volume_q;

endmodule

// File: tb/tb_noise_channel_sequencer.sv
// Directed bench for noise_channel_sequencer with FRAME_DIV=4. With reset
// released one cycle after an edge, the edges are counted from 1. A frame
// tick lands on every edge that is a multiple of 4, and the step after
// edge n is (n/4)%8.
module tb_noise_channel_sequencer;

  logic system_clock;
  logic reset;
  int unsigned cyc;
  int n_checks;
  int n_pass;

  noise_channel_sequencer_if bus ();

  noise_channel_sequencer #(.FRAME_DIV(4)) dut (
    .system_clock (system_clock),
    .reset        (reset),
    .bus          (bus)
  );

  initial system_clock = 1'b0;
  always #5 system_clock = ~system_clock;

  typedef struct {
    logic [7:0] nr42;
    logic [7:0] nr44;
    logic       w44;
    logic       wave;
    logic       exp_on;
    logic [3:0] exp_vol;
    logic       exp_restart;
    logic [3:0] exp_sample;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual !== expected)
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, cyc);
    else
      n_pass++;
  endtask

  task automatic clk_edge();
    @(posedge system_clock);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int unsigned target);
    while (cyc < target) begin
      clk_edge();
    end
  endtask

  task automatic idle_inputs();
    bus.nr41_write = 1'b0;
    bus.nr44_write = 1'b0;
    bus.NR41       = 8'h00;
    bus.NR44       = 8'h00;
    bus.wave       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    bus.NR42 = 8'h00;
    reset = 1'b1;
    @(posedge system_clock);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic write_nr44(input logic [7:0] value);
    bus.NR44 = value;
    bus.nr44_write = 1'b1;
    clk_edge();
    bus.nr44_write = 1'b0;
  endtask

  task automatic write_nr41(input logic [7:0] value);
    bus.NR41 = value;
    bus.nr41_write = 1'b1;
    clk_edge();
    bus.nr41_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;

    //            nr42   nr44   w44   wave  on    vol    rst   sample
    vecs[0]  = '{8'hF0, 8'h80, 1'b1, 1'b0, 1'b1, 4'd15, 1'b1, 4'd0};
    vecs[1]  = '{8'hF0, 8'h00, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0, 4'd15};
    vecs[2]  = '{8'hF0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd15, 1'b0, 4'd0};
    vecs[3]  = '{8'hF0, 8'h00, 1'b0, 1'b1, 1'b1, 4'd15, 1'b0, 4'd15};
    vecs[4]  = '{8'h30, 8'h80, 1'b1, 1'b1, 1'b1, 4'd3,  1'b1, 4'd15};
    vecs[5]  = '{8'h30, 8'h00, 1'b0, 1'b1, 1'b1, 4'd3,  1'b0, 4'd3};
    vecs[6]  = '{8'h07, 8'h00, 1'b0, 1'b1, 1'b0, 4'd3,  1'b0, 4'd3};
    vecs[7]  = '{8'h07, 8'h00, 1'b0, 1'b1, 1'b0, 4'd3,  1'b0, 4'd0};
    vecs[8]  = '{8'h07, 8'h80, 1'b1, 1'b1, 1'b0, 4'd0,  1'b1, 4'd0};
    vecs[9]  = '{8'h08, 8'h80, 1'b1, 1'b0, 1'b1, 4'd0,  1'b1, 4'd0};
    vecs[10] = '{8'h08, 8'h00, 1'b0, 1'b1, 1'b1, 4'd0,  1'b0, 4'd0};
    vecs[11] = '{8'h90, 8'h80, 1'b1, 1'b1, 1'b1, 4'd9,  1'b1, 4'd0};
    vecs[12] = '{8'h90, 8'h00, 1'b0, 1'b1, 1'b1, 4'd9,  1'b0, 4'd9};
    vecs[13] = '{8'h90, 8'h00, 1'b0, 1'b0, 1'b1, 4'd9,  1'b0, 4'd0};

    // Reset state.
    do_reset();
    check("reset channel_on", 8'(bus.channel_on), 8'd0);
    check("reset volume", 8'(bus.volume), 8'd0);
    check("reset lfsr_restart", 8'(bus.lfsr_restart), 8'd0);
    check("reset sample", 8'(bus.sample), 8'd0);

    // Trigger, sample scaling, DAC off and restart pulse, one edge per row.
    for (int i = 0; i < 14; i++) begin
      bus.NR42       = vecs[i].nr42;
      bus.NR44       = vecs[i].nr44;
      bus.nr44_write = vecs[i].w44;
      bus.wave       = vecs[i].wave;
      clk_edge();
      check($sformatf("vec%0d channel_on", i), 8'(bus.channel_on), 8'(vecs[i].exp_on));
      check($sformatf("vec%0d volume", i), 8'(bus.volume), 8'(vecs[i].exp_vol));
      check($sformatf("vec%0d lfsr_restart", i), 8'(bus.lfsr_restart), 8'(vecs[i].exp_restart));
      check($sformatf("vec%0d sample", i), 8'(bus.sample), 8'(vecs[i].exp_sample));
    end
    idle_inputs();

    // Length 2 with length enabled: the channel drops on the second
    // even-step tick (edge 16).
    do_reset();
    bus.NR42 = 8'hF0;
    write_nr41(8'h3E);
    write_nr44(8'hC0);
    check("len on after trigger", 8'(bus.channel_on), 8'd1);
    run_to(8);
    check("len on after 1st even tick", 8'(bus.channel_on), 8'd1);
    run_to(15);
    check("len on before 2nd even tick", 8'(bus.channel_on), 8'd1);
    run_to(16);
    check("len off at 2nd even tick", 8'(bus.channel_on), 8'd0);
    bus.wave = 1'b1;
    run_to(18);
    check("len sample after expiry", 8'(bus.sample), 8'd0);
    check("len stays off", 8'(bus.channel_on), 8'd0);

    // Envelope down from 5 with period 1. The step-7 ticks fall on
    // edges 28, 60, 92, ...
    do_reset();
    bus.NR42 = 8'h51;
    write_nr44(8'h80);
    check("env down start", 8'(bus.volume), 8'd5);
    run_to(27);
    check("env down before tick", 8'(bus.volume), 8'd5);
    for (int k = 0; k < 6; k++) begin
      run_to(28 + 32 * k);
      check($sformatf("env down tick%0d", k), 8'(bus.volume), 8'((k < 5) ? (4 - k) : 0));
    end
    // Envelope up from 14, triggered just after edge 188.
    bus.NR42 = 8'hE9;
    write_nr44(8'h80);
    check("env up start", 8'(bus.volume), 8'd14);
    run_to(219);
    check("env up before tick", 8'(bus.volume), 8'd14);
    run_to(220);
    check("env up reaches 15", 8'(bus.volume), 8'd15);
    run_to(252);
    check("env up frozen", 8'(bus.volume), 8'd15);

    // Asynchronous reset mid-operation at volume 9.
    do_reset();
    bus.NR42 = 8'h90;
    write_nr44(8'h80);
    check("pre-reset volume", 8'(bus.volume), 8'd9);
    check("pre-reset channel_on", 8'(bus.channel_on), 8'd1);
    #3;
    reset = 1'b1;
    #1;
    check("async reset volume", 8'(bus.volume), 8'd0);
    check("async reset channel_on", 8'(bus.channel_on), 8'd0);

    // Length 1, channel on, then length enabled by a write during step 0.
    do_reset();
    bus.NR42 = 8'hF0;
    write_nr41(8'h3F);
    write_nr44(8'h80);
    check("xlen on after trigger", 8'(bus.channel_on), 8'd1);
    write_nr44(8'h40);
`ifdef NOISE_SEQ_EXTRA_LEN_CLOCK_EN
    check("xlen off at write edge", 8'(bus.channel_on), 8'd0);
    run_to(8);
    check("xlen stays off", 8'(bus.channel_on), 8'd0);
`else
    check("xlen on at write edge", 8'(bus.channel_on), 8'd1);
    run_to(7);
    check("xlen on before even tick", 8'(bus.channel_on), 8'd1);
    run_to(8);
    check("xlen off at even tick", 8'(bus.channel_on), 8'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
